dram_cmd_scheduler: RTL
=======================

Name: dram_cmd_scheduler

Overview:
- Sits between the trace parser and the DRAM command/timing model.
- Accepts parsed memory requests, using the parser's strobe, opcode and address, into a 16-entry in-order queue.
- Decodes each address to bank group, bank, row and column.
- Sequences PRE/ACT/RD/WR commands under tRP/tRCD/tCCD minimums, with per-bank open-row tracking (open-page policy).

Parameters:
- ADDRESS_WIDTH, 33: request address width.
- QUEUE_DEPTH, 16: request queue entries. Power of 2.
- T_RCD, 24: minimum cycles from ACT to RD/WR, same bank.
- T_RP, 24: minimum cycles from PRE to ACT, same bank.
- T_CCD, 8: minimum cycles from RD/WR to the next command of any kind.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- op_ready_s  in  1  one-cycle strobe: opcode/address valid, push request.
- opcode  in  2  0=data read, 1=data write, 2=instruction fetch (treated as read), 3=reserved (ignored, not queued).
- address  in  ADDRESS_WIDTH  request byte address.
- queue_full  out  1  occupancy == QUEUE_DEPTH.
- queue_empty  out  1  occupancy == 0.
- drop_s  out  1  one-cycle pulse: strobed request rejected because full.
- cmd_valid  out  1  high exactly one cycle per issued command.
- cmd  out  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE.
- cmd_bank_group  out  2  address[7:6].
- cmd_bank  out  2  address[9:8].
- cmd_row  out  15  address[32:18].
- cmd_col  out  11  {address[17:10], address[5:3]}.

Behaviour:
- Reset (rst_n low at posedge):
  - queue emptied; FSM to IDLE; all 16 open-row entries invalidated; wait counter cleared.
  - Outputs: cmd_valid=0, cmd=NOP, cmd_* fields=0, drop_s=0, queue_full=0, queue_empty=1.
  - Reset mid-sequence aborts the in-flight request; no further command is issued for it.
- Push:
  - On op_ready_s with occupancy < QUEUE_DEPTH, write {opcode, address} at tail.
  - Full is evaluated before any same-cycle pop. A strobe while full is dropped and drop_s pulses the next cycle.
  - Opcode 3 is never queued and never sets drop_s.
- Head entry:
  - Stays in the queue until its RD/WR issues. It is popped at the end of that CAS cycle.
- FSM states:
  - IDLE: if queue not empty, latch head, go to DECODE.
  - DECODE:
    - bank open, row matches → CAS.
    - bank closed → ACT.
    - bank open, row differs → PRE.
  - PRE: cmd_valid=1, cmd=PRE; invalidate bank entry; load counter T_RP-1; go to PRE_WAIT.
  - PRE_WAIT: decrement; at 0 → ACT.
  - ACT: cmd_valid=1, cmd=ACT; record row as open for the bank; load T_RCD-1; go to ACT_WAIT.
  - ACT_WAIT: at 0 → CAS.
  - CAS: cmd_valid=1, cmd=RD (opcode 0/2) or WR (opcode 1); pop queue; load T_CCD-1; go to CAS_WAIT.
  - CAS_WAIT: at 0 → IDLE.
- Timing:
  - Issued command spacing equals the parameter exactly: ACT→CAS = T_RCD, PRE→ACT = T_RP.
  - CAS→next command = T_CCD+2, because of the IDLE and DECODE cycles.
- cmd fields carry the head request's decoded address during every command cycle. They hold their last value otherwise.
- Pointers wrap modulo QUEUE_DEPTH. Occupancy is QUEUE_DEPTH+1 states wide.
- Simultaneous push and pop when not full: occupancy unchanged.

Optional Feature:
- Macro: SCHED_CLOSED_PAGE_EN.
- When defined:
  - CAS_WAIT expiry goes to an AUTO_PRE state that issues PRE to the same bank and invalidates it.
  - Then T_RP-1 wait, then IDLE.
  - Every request therefore sees a closed bank and receives ACT.
- When undefined: open-page behaviour as above, and AUTO_PRE does not exist.

Test Plan:
- Reset, then read at address 0x0_0000_0000 → ACT BG0/B0 row 0 issues 3 cycles after the strobe. RD col 0 issues exactly 24 cycles later. queue_empty returns to 1 after the RD cycle.
- Reads at 0x0_0000_0000 then 0x0_0000_0400 (same row, col 8) → one ACT, RD col 0, RD col 8 issued 10 cycles later. No second ACT.
- Write at 0x0_0004_0000 (row 1) after a read at row 0 of BG0/B0 → PRE, ACT row 1 exactly 24 cycles later, WR 24 cycles after that.
- 17 back-to-back strobes from empty → queue_full asserts after the 16th push. The 17th strobe is dropped with a drop_s pulse. Exactly 16 CAS commands issue in push order.
- Assert rst_n=0 during ACT_WAIT → next cycle cmd_valid=0 and queue_empty=1. The next request to the same bank gets a fresh ACT, not a CAS.
- SCHED_CLOSED_PAGE_EN defined, two same-row reads → ACT, RD, PRE, ACT, RD, PRE sequence. ACT→RD gap is 24 in each case.

Source files
------------

// File: rtl/dram_cmd_scheduler.sv
// rtl/dram_cmd_scheduler.sv - in-order DRAM request queue and PRE/ACT/RD/WR sequencer.
// Optional closed-page mode (auto PRE after every CAS) under `SCHED_CLOSED_PAGE_EN.
module dram_cmd_scheduler #(
  parameter int ADDRESS_WIDTH = 33,
  parameter int QUEUE_DEPTH   = 16,
  parameter int T_RCD         = 24,
  parameter int T_RP          = 24,
  parameter int T_CCD         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_ready_s,
  input  logic [1:0]               opcode,
  input  logic [ADDRESS_WIDTH-1:0] address,
  output logic                     queue_full,
  output logic                     queue_empty,
  output logic                     drop_s,
  output logic                     cmd_valid,
  output logic [2:0]               cmd,
  output logic [1:0]               cmd_bank_group,
  output logic [1:0]               cmd_bank,
  output logic [14:0]              cmd_row,
  output logic [10:0]              cmd_col
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int OCC_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int T_MAX   = (T_RCD > T_RP) ? ((T_RCD > T_CCD) ? T_RCD : T_CCD)
                                          : ((T_RP > T_CCD) ? T_RP : T_CCD);
  localparam int WAIT_W  = $clog2(T_MAX + 1);
  localparam int ADDR_KW = ADDRESS_WIDTH - 3;
  localparam int ENTRY_W = ADDR_KW + 2;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DECODE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_CAS,
    ST_CAS_WAIT
`ifdef SCHED_CLOSED_PAGE_EN
    , ST_AUTO_PRE,
    ST_AUTO_PRE_WAIT
`endif
  } state_t;

  // The byte offset inside a burst never affects a command, so it is not stored.
  logic unused_byte_ofs;
  assign unused_byte_ofs = ^address[2:0];

  logic [ENTRY_W-1:0] mem_q [QUEUE_DEPTH];
  logic [ENTRY_W-1:0] mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               drop_q, drop_d;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         head_op_q, head_op_d;
  logic [ADDR_KW-1:0] head_addr_q, head_addr_d;
  logic [15:0]        row_vld_q, row_vld_d;
  logic [14:0]        row_tbl_q [16];
  logic [14:0]        row_tbl_d [16];

  logic               cmd_valid_q, cmd_valid_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [1:0]         bg_q, bg_d;
  logic [1:0]         bank_q, bank_d;
  logic [14:0]        row_q, row_d;
  logic [10:0]        col_q, col_d;

  logic               q_full, q_empty, push, pop;
  logic [1:0]         head_bg, head_bank;
  logic [3:0]         head_bidx;
  logic [14:0]        head_row;
  logic [10:0]        head_col;
  logic [2:0]         cas_cmd;
  logic [WAIT_W-1:0]  wait_dec;
  logic               wait_done;
  logic               issue;
  logic [2:0]         issue_cmd;

  assign q_full  = (occ_q == OCC_W'(QUEUE_DEPTH));
  assign q_empty = (occ_q == '0);
  assign push    = op_ready_s && (opcode != OP_RSVD) && !q_full;
  assign pop     = (state_q == ST_CAS);

  // Stored address is byte address >> 3, so decode indices are shifted down by 3.
  assign head_bg   = head_addr_q[4:3];
  assign head_bank = head_addr_q[6:5];
  assign head_bidx = {head_bg, head_bank};
  assign head_row  = head_addr_q[29:15];
  assign head_col  = {head_addr_q[14:7], head_addr_q[2:0]};
  assign cas_cmd   = (head_op_q == OP_WRITE) ? CMD_WR : CMD_RD;
  assign wait_dec  = wait_q - 1'b1;
  assign wait_done = (wait_dec == '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    drop_d   = op_ready_s && (opcode != OP_RSVD) && q_full;
    if (push) begin
      mem_d[wr_ptr_q] = {opcode, address[ADDRESS_WIDTH-1:3]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!push && pop) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    head_op_d   = head_op_q;
    head_addr_d = head_addr_q;
    row_vld_d   = row_vld_q;
    row_tbl_d   = row_tbl_q;
    issue       = 1'b0;
    issue_cmd   = CMD_NOP;
    unique case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          {head_op_d, head_addr_d} = mem_q[rd_ptr_q];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        issue = 1'b1;
        if (row_vld_q[head_bidx] && (row_tbl_q[head_bidx] == head_row)) begin
          issue_cmd = cas_cmd;
          state_d   = ST_CAS;
        end else if (row_vld_q[head_bidx]) begin
          issue_cmd = CMD_PRE;
          state_d   = ST_PRE;
        end else begin
          issue_cmd = CMD_ACT;
          state_d   = ST_ACT;
        end
      end
      ST_PRE: begin
        row_vld_d[head_bidx] = 1'b0;
        wait_d  = WAIT_W'(T_RP - 1);
        state_d = ST_PRE_WAIT;
      end
      ST_PRE_WAIT: begin
        wait_d = wait_dec;
        if (wait_done) begin
          issue     = 1'b1;
          issue_cmd = CMD_ACT;
          state_d   = ST_ACT;
        end
      end
      ST_ACT: begin
        row_vld_d[head_bidx] = 1'b1;
        row_tbl_d[head_bidx] = head_row;
        wait_d  = WAIT_W'(T_RCD - 1);
        state_d = ST_ACT_WAIT;
      end
      ST_ACT_WAIT: begin
        wait_d = wait_dec;
        if (wait_done) begin
          issue     = 1'b1;
          issue_cmd = cas_cmd;
          state_d   = ST_CAS;
        end
      end
      ST_CAS: begin
        wait_d  = WAIT_W'(T_CCD - 1);
        state_d = ST_CAS_WAIT;
      end
      ST_CAS_WAIT: begin
        wait_d = wait_dec;
        if (wait_done) begin
`ifdef SCHED_CLOSED_PAGE_EN
          issue     = 1'b1;
          issue_cmd = CMD_PRE;
          state_d   = ST_AUTO_PRE;
`else
          state_d   = ST_IDLE;
`endif
        end
      end
`ifdef SCHED_CLOSED_PAGE_EN
      ST_AUTO_PRE: begin
        row_vld_d[head_bidx] = 1'b0;
        wait_d  = WAIT_W'(T_RP - 1);
        state_d = ST_AUTO_PRE_WAIT;
      end
      ST_AUTO_PRE_WAIT: begin
        wait_d = wait_dec;
        if (wait_done) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered: a command is presented in the cycle its state is entered.
    cmd_valid_d = issue;
    cmd_d       = issue ? issue_cmd : CMD_NOP;
    bg_d        = issue ? head_bg   : bg_q;
    bank_d      = issue ? head_bank : bank_q;
    row_d       = issue ? head_row  : row_q;
    col_d       = issue ? head_col  : col_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      drop_q      <= 1'b0;
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      head_op_q   <= '0;
      head_addr_q <= '0;
      row_vld_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      bg_q        <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      wait_q      <= wait_d;
      head_op_q   <= head_op_d;
      head_addr_q <= head_addr_d;
      row_vld_q   <= row_vld_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      bg_q        <= bg_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
    end
    mem_q     <= mem_d;
    row_tbl_q <= row_tbl_d;
  end

  assign queue_full     = q_full;
  assign queue_empty    = q_empty;
  assign drop_s         = drop_q;
  assign cmd_valid      = cmd_valid_q;
  assign cmd            = cmd_q;
  assign cmd_bank_group = bg_q;
  assign cmd_bank       = bank_q;
  assign cmd_row        = row_q;
  assign cmd_col        = col_q;

endmodule
